// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, baud divider helper, frame constants.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Clock cycles per line bit, integer truncation.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port and occupancy count.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks push/pop, unchanged when both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8-bit serialiser with optional even parity.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx_data_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUDRATE);
  localparam int unsigned BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BIT_W    = $clog2(UART_DATA_BITS);

  // Reject unsupported configurations at elaboration.
  if (BAUD_DIV < 2) begin : g_chk_baud
    $error("uart_tx_buffered: CLK_FREQ/BAUDRATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end

  logic                              w_push;
  logic                              w_pop;
  logic [UART_DATA_BITS-1:0]         w_head;
  logic                              w_bit_end;

  tx_state_e                         r_state;
  tx_state_e                         w_state_nxt;
  logic [BAUD_W-1:0]                 r_baud;
  logic [BAUD_W-1:0]                 w_baud_nxt;
  logic [BIT_W-1:0]                  r_bit;
  logic [BIT_W-1:0]                  w_bit_nxt;
  logic [UART_DATA_BITS-1:0]         r_shift;
  logic [UART_DATA_BITS-1:0]         w_shift_nxt;
  logic                              w_line_nxt;
  logic                              w_busy_nxt;

  assign wr_ready = ~fifo_full;
  assign w_push   = wr_valid & wr_ready;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (wr_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_count     (fifo_count),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full)
  );

  assign w_bit_end = (r_baud == BAUD_W'(BAUD_DIV - 1));

  // Next-state, pop request and next line level; line/busy are computed from the
  // next state so the registered outputs line up with the state they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_line_nxt  = 1'b1;
    w_busy_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        if (!fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_bit_nxt   = '0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == BIT_W'(UART_DATA_BITS - 1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == BIT_W'(STOP_BITS - 1)) begin
            w_bit_nxt = '0;
            if (!fifo_empty) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_head;
              w_state_nxt = ST_START;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    case (w_state_nxt)
      ST_START:  w_line_nxt = 1'b0;
      ST_DATA:   w_line_nxt = w_shift_nxt[w_bit_nxt];
      ST_PARITY: w_line_nxt = ^w_shift_nxt;
      default:   w_line_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, timing counters, shifter and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_baud      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      tx_data_out <= 1'b1;
      tx_busy     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_baud      <= w_baud_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      tx_data_out <= w_line_nxt;
      tx_busy     <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: dut0 is 8N1, dut1 adds even parity; both BAUD_DIV=8.
module tb_uart_tx_buffered;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] vld;
  logic [7:0] dat0;
  logic [7:0] dat1;
  logic [1:0] rdy;
  logic [1:0] line;
  logic [1:0] busy;
  logic [1:0] empty;
  logic [1:0] full;
  logic [4:0] cnt0;
  logic [4:0] cnt1;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLK_FREQ(8), .BAUDRATE(1), .FIFO_DEPTH(16), .PARITY_EN(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst(rst), .wr_valid(vld[0]), .wr_data(dat0), .wr_ready(rdy[0]),
    .tx_data_out(line[0]), .tx_busy(busy[0]), .fifo_count(cnt0),
    .fifo_empty(empty[0]), .fifo_full(full[0])
  );

  uart_tx_buffered #(
    .CLK_FREQ(8), .BAUDRATE(1), .FIFO_DEPTH(16), .PARITY_EN(1), .STOP_BITS(1)
  ) dut1 (
    .clk(clk), .rst(rst), .wr_valid(vld[1]), .wr_data(dat1), .wr_ready(rdy[1]),
    .tx_data_out(line[1]), .tx_busy(busy[1]), .fifo_count(cnt1),
    .fifo_empty(empty[1]), .fifo_full(full[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [4:0] cnt_of(input int g);
    return (g == 0) ? cnt0 : cnt1;
  endfunction

  // Serial line decoder per DUT: captures each bit at its first cycle, flags any
  // change within a bit period, and scores the frame against the expected queue.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int NB = (g == 1) ? 11 : 10;
    logic        prev   = 1'b1;
    logic        act    = 1'b0;
    logic        glitch = 1'b0;
    logic [10:0] bits   = '0;
    logic [7:0]  e;
    int          cyc    = 0;
    int          frames = 0;

    always @(negedge clk) begin
      if (rst) begin
        act  = 1'b0;
        prev = 1'b1;
      end else begin
        if (!act && prev && !line[g]) begin
          act    = 1'b1;
          cyc    = 0;
          glitch = 1'b0;
          bits   = '0;
        end
        if (act) begin
          if (cyc % DIV == 0) bits[cyc / DIV] = line[g];
          else if (line[g] !== bits[cyc / DIV]) glitch = 1'b1;
          cyc++;
          if (cyc == NB * DIV) begin
            act = 1'b0;
            frames++;
            chk($sformatf("dut%0d sb_nonempty", g), 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 8'h00;
            chk($sformatf("dut%0d start_bit", g), 32'(bits[0]), 32'd0);
            chk($sformatf("dut%0d data", g), 32'(bits[8:1]), 32'(e));
            chk($sformatf("dut%0d bit9", g), 32'(bits[9]), 32'((NB == 11) ? ^e : 1'b1));
            chk($sformatf("dut%0d stop_bit", g), 32'(bits[NB-1]), 32'd1);
            chk($sformatf("dut%0d bit_width", g), 32'(glitch), 32'd0);
          end
        end
        prev = line[g];
      end
    end
  end

  // Offer one byte for one edge; called at a negedge, returns at the next negedge.
  task automatic step(input int g, input logic [7:0] d, output logic acc);
    acc = rdy[g];
    if (g == 0) dat0 = d;
    else        dat1 = d;
    vld[g] = 1'b1;
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    vld[g] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_busy(input int g, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy[g]) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int g, input int budget);
    int n;
    n = 0;
    while ((busy[g] || !empty[g]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d drain", g), 32'(busy[g] || !empty[g]), 32'd0);
    idle(2);
  endtask

  initial begin
    logic acc;
    int   nb;
    int   nacc;
    logic [7:0] simul [5];

    rst  = 1'b1;
    vld  = '0;
    dat0 = '0;
    dat1 = '0;
    idle(3);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("dut%0d rst_line", g),  32'(line[g]),   32'd1);
      chk($sformatf("dut%0d rst_busy", g),  32'(busy[g]),   32'd0);
      chk($sformatf("dut%0d rst_count", g), 32'(cnt_of(g)), 32'd0);
      chk($sformatf("dut%0d rst_empty", g), 32'(empty[g]),  32'd1);
      chk($sformatf("dut%0d rst_full", g),  32'(full[g]),   32'd0);
      chk($sformatf("dut%0d rst_ready", g), 32'(rdy[g]),    32'd1);
    end
    rst = 1'b0;
    idle(2);

    // Single byte: start bit one cycle after accept, busy for 10 bit periods.
    step(0, 8'h55, acc);
    chk("single accept", 32'(acc), 32'd1);
    chk("single line_after_accept", 32'(line[0]), 32'd1);
    chk("single busy_after_accept", 32'(busy[0]), 32'd0);
    chk("single count_after_accept", 32'(cnt0), 32'd1);
    idle(1);
    chk("single line_after_pop", 32'(line[0]), 32'd0);
    chk("single busy_after_pop", 32'(busy[0]), 32'd1);
    chk("single count_after_pop", 32'(cnt0), 32'd0);
    count_busy(0, nb);
    chk("single busy_cycles", 32'(nb), 32'd80);
    wait_idle(0, 200);

    // Parity frames: 11 bit periods each.
    step(1, 8'hA5, acc);
    count_busy(1, nb);
    chk("parity_a5 busy_cycles", 32'(nb), 32'd88);
    wait_idle(1, 200);
    step(1, 8'h01, acc);
    count_busy(1, nb);
    chk("parity_01 busy_cycles", 32'(nb), 32'd88);
    wait_idle(1, 200);

    // Fill: 20 offered from idle, 17 accepted (one popped immediately).
    nacc = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 8'(8'h10 + i), acc);
      if (acc) nacc++;
    end
    chk("full accepted", 32'(nacc), 32'd17);
    chk("full fifo_full", 32'(full[0]), 32'd1);
    chk("full wr_ready", 32'(rdy[0]), 32'd0);
    chk("full count", 32'(cnt0), 32'd16);
    wait_idle(0, 17 * 80 + 200);

    // Back-to-back: 0x00/0xFF queued behind 0x3C; no idle gap between frames.
    step(0, 8'h3C, acc);
    step(0, 8'h00, acc);
    step(0, 8'hFF, acc);
    chk("b2b count_queued", 32'(cnt0), 32'd2);
    idle(78);
    chk("b2b count_before_pop1", 32'(cnt0), 32'd2);
    chk("b2b stop_line", 32'(line[0]), 32'd1);
    idle(1);
    chk("b2b count_after_pop1", 32'(cnt0), 32'd1);
    chk("b2b start_no_gap1", 32'(line[0]), 32'd0);
    idle(80);
    chk("b2b count_after_pop2", 32'(cnt0), 32'd0);
    chk("b2b start_no_gap2", 32'(line[0]), 32'd0);
    wait_idle(0, 400);

    // Push on the same edge as a pop at occupancy 3.
    simul[0] = 8'h81; simul[1] = 8'h42; simul[2] = 8'h24; simul[3] = 8'h18; simul[4] = 8'hE7;
    for (int i = 0; i < 4; i++) step(0, simul[i], acc);
    chk("simul count_before", 32'(cnt0), 32'd3);
    idle(77);
    chk("simul count_pre_edge", 32'(cnt0), 32'd3);
    step(0, simul[4], acc);
    chk("simul accept", 32'(acc), 32'd1);
    chk("simul count_after", 32'(cnt0), 32'd3);
    chk("simul start_line", 32'(line[0]), 32'd0);
    wait_idle(0, 600);

    // Reset during data bit 4 (0x4A bit4 = 0) with one more byte queued.
    step(0, 8'h4A, acc);
    step(0, 8'hC3, acc);
    idle(42);
    chk("rstmid line_bit4", 32'(line[0]), 32'd0);
    chk("rstmid busy_before", 32'(busy[0]), 32'd1);
    chk("rstmid count_before", 32'(cnt0), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    idle(1);
    chk("rstmid line", 32'(line[0]), 32'd1);
    chk("rstmid busy", 32'(busy[0]), 32'd0);
    chk("rstmid count", 32'(cnt0), 32'd0);
    chk("rstmid empty", 32'(empty[0]), 32'd1);
    chk("rstmid ready", 32'(rdy[0]), 32'd1);
    idle(1);
    rst = 1'b0;
    idle(20);
    chk("rstmid no_resume_busy", 32'(busy[0]), 32'd0);
    chk("rstmid no_resume_line", 32'(line[0]), 32'd1);
    step(0, 8'h96, acc);
    count_busy(0, nb);
    chk("rstmid clean_busy_cycles", 32'(nb), 32'd80);
    wait_idle(0, 200);

    chk("sb leftover", 32'(exp_q.size()), 32'd0);
    chk("dut0 frames", 32'(g_mon[0].frames), 32'd27);
    chk("dut1 frames", 32'(g_mon[1].frames), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
